ex_hazard_ctrl: RTL and testbench

- Pipeline sequencing controller for the ID/EX/MEM/WB segment chain. It has no forwarding path.
- Decodes the instruction waiting in ID and tracks in-flight destination registers in a 3-slot scoreboard (EX, MEM, WB).
- Generates PC/IF-ID write enables, ID/EX bubble and IF-ID/EX-MEM flush controls.
- Resolves RAW hazards by stalling and handles control transfers by interlock, or by predict-not-taken when the optional feature is enabled.

---
 rtl/ex_hazard_ctrl.sv | 106 ++++++++++
 tb/tb_ex_hazard_ctrl.sv | 120 ++++++++++++
 2 files changed

// File: rtl/ex_hazard_ctrl.sv
// ex_hazard_ctrl: RAW stall and branch sequencing for ID/EX/MEM/WB; define PREDICT_NT_EN for predict-not-taken
module ex_hazard_ctrl #(
    parameter int WB_BYPASS = 1,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      id_ir,
    input  logic             id_valid,
    input  logic             mem_br_valid,
    input  logic             mem_br_taken,
    output logic             pc_we,
    output logic             ifid_we,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic             raw_stall,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [1:0]       state
);
`ifdef PREDICT_NT_EN
    localparam bit PNT = 1'b1;
`else
    localparam bit PNT = 1'b0;
`endif
    typedef enum logic [1:0] {RUN, RAW, BR_WAIT, FLUSH} state_t;
    state_t st, st_nx;
    logic [5:0] op;
    logic [4:0] rs, rt, dst, ex_d, mem_d, wb_d;
    logic ex_v, mem_v, wb_v, use_rs, use_rt, has_dst, xfer;
    logic hit_rs, hit_rt, raw, issue, run_like, flush, unused;
    assign op = id_ir[31:26];
    assign rs = id_ir[25:21];
    assign rt = id_ir[20:16];
    assign unused = ^id_ir[10:0];
    assign xfer = op == 6'b000100 || op == 6'b000010;
    assign use_rs = op != 6'b000010 && rs != 5'd0;
    assign use_rt = (op == 6'b000000 || op == 6'b101011) && rt != 5'd0;
    assign dst = op == 6'b000000 ? id_ir[15:11] : rt;
    assign has_dst = !(op == 6'b101011 || xfer) && dst != 5'd0;
    assign hit_rs = (ex_v && ex_d == rs) || (mem_v && mem_d == rs) || (WB_BYPASS == 0 && wb_v && wb_d == rs);
    assign hit_rt = (ex_v && ex_d == rt) || (mem_v && mem_d == rt) || (WB_BYPASS == 0 && wb_v && wb_d == rt);
    assign raw = id_valid && ((use_rs && hit_rs) || (use_rt && hit_rt));
    assign run_like = st == RUN || st == RAW;
    assign flush = PNT && mem_br_valid && mem_br_taken;
    assign issue = id_valid && !raw && run_like && !flush;
    assign state = st;
    always_comb begin
        st_nx = RUN;
        pc_we = 1'b1;
        ifid_we = 1'b1;
        ifid_flush = 1'b0;
        idex_bubble = !issue;
        exmem_flush = 1'b0;
        raw_stall = 1'b0;
        if (flush) begin
            ifid_flush = 1'b1;
            exmem_flush = 1'b1;
            st_nx = FLUSH;
        end else if (run_like && raw) begin
            pc_we = 1'b0;
            ifid_we = 1'b0;
            raw_stall = 1'b1;
            st_nx = RAW;
        end else if (run_like) begin
            ifid_flush = issue && xfer && !PNT;
            st_nx = ifid_flush ? BR_WAIT : RUN;
        end else if (st == BR_WAIT) begin
            pc_we = mem_br_valid;
            ifid_we = 1'b0;
            st_nx = mem_br_valid ? RUN : BR_WAIT;
        end
        if (rst) begin
            pc_we = 1'b1;
            ifid_we = 1'b1;
            ifid_flush = 1'b0;
            idex_bubble = 1'b0;
            exmem_flush = 1'b0;
            raw_stall = 1'b0;
            st_nx = RUN;
        end
    end
    // a taken resolution squashes whatever sits in EX, so its destination never reaches MEM/WB
    always_ff @(posedge clk) begin
        if (rst) begin
            st <= RUN;
            ex_v <= 1'b0;
            mem_v <= 1'b0;
            wb_v <= 1'b0;
            ex_d <= 5'd0;
            mem_d <= 5'd0;
            wb_d <= 5'd0;
            stall_cnt <= '0;
        end else begin
            st <= st_nx;
            ex_v <= issue && has_dst;
            ex_d <= dst;
            mem_v <= ex_v && !flush;
            mem_d <= ex_d;
            wb_v <= mem_v && !flush;
            wb_d <= mem_d;
            if (!pc_we && !(&stall_cnt))
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// tb_ex_hazard_ctrl: scoreboard bench driving a WB_BYPASS=1 and a WB_BYPASS=0 instance in lockstep
module tb_ex_hazard_ctrl;
    logic clk = 1'b0, rst = 1'b1, id_valid = 1'b0, mem_br_valid = 1'b0, mem_br_taken = 1'b0;
    logic [31:0] id_ir = 32'd0;
    logic pc_we_a, ifid_we_a, ifid_flush_a, idex_bubble_a, exmem_flush_a, raw_stall_a;
    logic pc_we_b, ifid_we_b, ifid_flush_b, idex_bubble_b, exmem_flush_b, raw_stall_b;
    logic [15:0] cnt_a, cnt_b;
    logic [1:0] state_a, state_b;
    logic [7:0] vec_a, vec_b;
    int n_vec = 0, n_bad = 0;
    // control vector: {pc_we, ifid_we, ifid_flush, idex_bubble, exmem_flush, raw_stall, state}
    localparam logic [7:0] ISS = 8'b1100_0000, ISS_R = 8'b1100_0001, IDL = 8'b1101_0000;
    localparam logic [7:0] ST0 = 8'b0001_0100, ST1 = 8'b0001_0101, BRI = 8'b1110_0000;
    localparam logic [7:0] BRW = 8'b0001_0010, BRR = 8'b1001_0010, FLT = 8'b1111_1000, FLS = 8'b1101_0011;
    typedef struct {
        string nm;
        logic [7:0] ca;
        logic [15:0] na;
        logic [7:0] cb;
        logic [15:0] nb;
    } exp_t;
    exp_t q[$];
    exp_t e;
    ex_hazard_ctrl #(.WB_BYPASS(1), .CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .id_ir(id_ir), .id_valid(id_valid),
        .mem_br_valid(mem_br_valid), .mem_br_taken(mem_br_taken),
        .pc_we(pc_we_a), .ifid_we(ifid_we_a), .ifid_flush(ifid_flush_a),
        .idex_bubble(idex_bubble_a), .exmem_flush(exmem_flush_a),
        .raw_stall(raw_stall_a), .stall_cnt(cnt_a), .state(state_a));
    ex_hazard_ctrl #(.WB_BYPASS(0), .CNT_W(16)) dut_b (
        .clk(clk), .rst(rst), .id_ir(id_ir), .id_valid(id_valid),
        .mem_br_valid(mem_br_valid), .mem_br_taken(mem_br_taken),
        .pc_we(pc_we_b), .ifid_we(ifid_we_b), .ifid_flush(ifid_flush_b),
        .idex_bubble(idex_bubble_b), .exmem_flush(exmem_flush_b),
        .raw_stall(raw_stall_b), .stall_cnt(cnt_b), .state(state_b));
    assign vec_a = {pc_we_a, ifid_we_a, ifid_flush_a, idex_bubble_a, exmem_flush_a, raw_stall_a, state_a};
    assign vec_b = {pc_we_b, ifid_we_b, ifid_flush_b, idex_bubble_b, exmem_flush_b, raw_stall_b, state_b};
    always #5 clk = ~clk;
    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            n_vec++;
            if (vec_a !== e.ca || cnt_a !== e.na) begin
                n_bad++;
                $display("FAIL %s bypass1: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d", e.nm, vec_a, cnt_a, e.ca, e.na);
            end
            n_vec++;
            if (vec_b !== e.cb || cnt_b !== e.nb) begin
                n_bad++;
                $display("FAIL %s bypass0: got ctl=%b cnt=%0d, want ctl=%b cnt=%0d", e.nm, vec_b, cnt_b, e.cb, e.nb);
            end
        end
    end
    function automatic logic [31:0] r_ins(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
        return {6'b000000, s, t, d, 5'd0, 6'h20};
    endfunction
    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] s, input logic [4:0] t);
        return {op, s, t, 16'h0004};
    endfunction
    task automatic step(input logic r, input logic v, input logic [31:0] ir, input logic bv, input logic bt,
                        input string nm, input logic [7:0] ca, input logic [15:0] na,
                        input logic [7:0] cb, input logic [15:0] nb);
        rst = r;
        id_valid = v;
        id_ir = ir;
        mem_br_valid = bv;
        mem_br_taken = bt;
        q.push_back('{nm, ca, na, cb, nb});
        @(posedge clk);
        #1;
    endtask
    initial begin
        repeat (2) @(posedge clk);
        #1;
        step(1, 0, 0, 0, 0, "reset", ISS, 0, ISS, 0);
        step(0, 1, r_ins(3, 1, 2), 0, 0, "add_r3", ISS, 0, ISS, 0);
        step(0, 1, r_ins(4, 3, 0), 0, 0, "raw_ex", ST0, 0, ST0, 0);
        step(0, 1, r_ins(4, 3, 0), 0, 0, "raw_mem", ST1, 1, ST1, 1);
        step(0, 1, r_ins(4, 3, 0), 0, 0, "raw_wb", ISS_R, 2, ST1, 2);
        step(0, 1, r_ins(4, 3, 0), 0, 0, "wb_done", ISS, 2, ISS_R, 3);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, "drain1", IDL, 2, IDL, 3);
        step(0, 1, i_ins(6'b100011, 0, 5), 0, 0, "lw_r5", ISS, 2, ISS, 3);
        step(0, 1, i_ins(6'b101011, 0, 5), 0, 0, "sw_ex", ST0, 2, ST0, 3);
        step(0, 1, i_ins(6'b101011, 0, 5), 0, 0, "sw_mem", ST1, 3, ST1, 4);
        step(0, 1, i_ins(6'b101011, 0, 5), 0, 0, "sw_wb", ISS_R, 4, ST1, 5);
        step(0, 1, i_ins(6'b101011, 0, 5), 0, 0, "sw_go", ISS, 4, ISS_R, 6);
        step(0, 1, r_ins(0, 1, 2), 0, 0, "add_r0", ISS, 4, ISS, 6);
        step(0, 1, r_ins(6, 0, 0), 0, 0, "read_r0", ISS, 4, ISS, 6);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, "drain2", IDL, 4, IDL, 6);
        step(0, 1, r_ins(3, 1, 2), 0, 0, "rst_add", ISS, 4, ISS, 6);
        step(0, 1, r_ins(4, 3, 0), 0, 0, "rst_raw", ST0, 4, ST0, 6);
        step(1, 1, r_ins(4, 3, 0), 0, 0, "rst_mid", ISS_R, 5, ISS_R, 7);
        step(0, 1, r_ins(4, 3, 0), 0, 0, "post_rst", ISS, 0, ISS, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, "drain3", IDL, 0, IDL, 0);
`ifdef PREDICT_NT_EN
        step(0, 1, i_ins(6'b000100, 1, 2), 0, 0, "beq_pnt", ISS, 0, ISS, 0);
        step(0, 1, r_ins(7, 1, 2), 0, 0, "add_r7", ISS, 0, ISS, 0);
        step(0, 1, r_ins(9, 7, 0), 1, 1, "taken", FLT, 0, FLT, 0);
        step(0, 1, r_ins(9, 7, 0), 0, 0, "flush_st", FLS, 0, FLS, 0);
        step(0, 1, r_ins(9, 7, 0), 0, 0, "r7_free", ISS, 0, ISS, 0);
        step(0, 0, 0, 1, 0, "nt_idle", IDL, 0, IDL, 0);
        step(0, 1, r_ins(10, 1, 2), 1, 0, "nt_issue", ISS, 0, ISS, 0);
`else
        step(0, 1, i_ins(6'b000100, 1, 2), 0, 0, "beq_issue", BRI, 0, BRI, 0);
        step(0, 0, 0, 0, 0, "br_wait1", BRW, 0, BRW, 0);
        step(0, 0, 0, 0, 0, "br_wait2", BRW, 1, BRW, 1);
        step(0, 0, 0, 1, 1, "br_resolve", BRR, 2, BRR, 2);
        step(0, 0, 0, 0, 0, "br_run", IDL, 2, IDL, 2);
        step(0, 1, i_ins(6'b000010, 0, 0), 0, 0, "j_issue", BRI, 2, BRI, 2);
        step(0, 0, 0, 1, 0, "j_resolve", BRR, 2, BRR, 2);
`endif
        n_vec++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
